// File: rtl/tnn_feature_streamer.sv
// Streams feature beats into the flat classifier input vector, waits for the classifier
// to settle, then returns its prediction with a sample index. Optional: TNN_LABEL_CHECK_EN.
module tnn_feature_streamer #(
  parameter int unsigned FEAT_CNT      = 12,
  parameter int unsigned FEAT_BITS     = 4,
  parameter int unsigned CLASS_CNT     = 6,
  parameter int unsigned TEST_CNT      = 1000,
  parameter int unsigned SETTLE_CYCLES = 1,
  localparam int unsigned PRED_BITS    = $clog2(CLASS_CNT),
  localparam int unsigned IDX_BITS     = $clog2(TEST_CNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [FEAT_BITS-1:0]          s_data,
  input  logic                          s_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [PRED_BITS-1:0]          prediction,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [PRED_BITS-1:0]          m_pred,
  output logic [IDX_BITS-1:0]           m_index,
  output logic                          done,
  output logic                          err
`ifdef TNN_LABEL_CHECK_EN
  , input  logic [PRED_BITS-1:0]          s_label
  , output logic [$clog2(TEST_CNT+1)-1:0] correct_cnt
`endif
);

  localparam int unsigned FIDX_BITS = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int unsigned SCNT_BITS = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned FVEC_BITS = FEAT_CNT * FEAT_BITS;
`ifdef TNN_LABEL_CHECK_EN
  localparam int unsigned CORR_BITS = $clog2(TEST_CNT + 1);
`endif

  typedef enum logic [1:0] {LOAD, SETTLE, OUT, DONE} state_t;

  state_t                 r_state,      w_state;
  logic [FIDX_BITS-1:0]   r_feat_idx,   w_feat_idx;
  logic [IDX_BITS-1:0]    r_sample_cnt, w_sample_cnt;
  logic [SCNT_BITS-1:0]   r_settle_cnt, w_settle_cnt;
  logic [FVEC_BITS-1:0]   r_features,   w_features;
  logic                   r_s_ready,    w_s_ready;
  logic                   r_m_valid,    w_m_valid;
  logic [PRED_BITS-1:0]   r_m_pred,     w_m_pred;
  logic [IDX_BITS-1:0]    r_m_index,    w_m_index;
  logic                   r_done,       w_done;
  logic                   r_err,        w_err;
`ifdef TNN_LABEL_CHECK_EN
  logic [PRED_BITS-1:0]   r_label,      w_label;
  logic [CORR_BITS-1:0]   r_correct,    w_correct;
`endif

  logic w_beat;
  logic w_final;
  logic w_hs;
  logic w_wr;

  assign w_beat  = s_valid & r_s_ready;
  assign w_final = (r_feat_idx == FIDX_BITS'(FEAT_CNT - 1));
  assign w_hs    = r_m_valid & m_ready;

  // Next-state and next-output logic
  always_comb begin
    w_state      = r_state;
    w_feat_idx   = r_feat_idx;
    w_sample_cnt = r_sample_cnt;
    w_settle_cnt = r_settle_cnt;
    w_features   = r_features;
    w_m_valid    = r_m_valid;
    w_m_pred     = r_m_pred;
    w_m_index    = r_m_index;
    w_err        = r_err;
    w_wr         = 1'b0;
`ifdef TNN_LABEL_CHECK_EN
    w_label      = r_label;
    w_correct    = r_correct;
`endif

    unique case (r_state)
      LOAD: begin
        if (w_beat) begin
          if (w_final) begin
            w_wr         = 1'b1;
            w_err        = r_err | ~s_last;
            w_feat_idx   = '0;
            w_settle_cnt = SCNT_BITS'(SETTLE_CYCLES);
            w_state      = SETTLE;
`ifdef TNN_LABEL_CHECK_EN
            w_label      = s_label;
`endif
          end else if (s_last) begin
            // Early s_last aborts the sample; stale slots are left in place
            w_err      = 1'b1;
            w_feat_idx = '0;
          end else begin
            w_wr       = 1'b1;
            w_feat_idx = r_feat_idx + FIDX_BITS'(1);
          end
        end
      end
      SETTLE: begin
        w_settle_cnt = r_settle_cnt - SCNT_BITS'(1);
        if (r_settle_cnt == SCNT_BITS'(1)) begin
          w_m_pred  = prediction;
          w_m_index = r_sample_cnt;
          w_m_valid = 1'b1;
          w_state   = OUT;
        end
      end
      OUT: begin
        if (w_hs) begin
          w_m_valid = 1'b0;
`ifdef TNN_LABEL_CHECK_EN
          if (r_m_pred == r_label) begin
            w_correct = r_correct + CORR_BITS'(1);
          end
`endif
          if (r_sample_cnt == IDX_BITS'(TEST_CNT - 1)) begin
            w_state = DONE;
          end else begin
            w_sample_cnt = r_sample_cnt + IDX_BITS'(1);
            w_state      = LOAD;
          end
        end
      end
      DONE: begin
        w_m_valid = 1'b0;
      end
      default: begin
        w_state = LOAD;
      end
    endcase

    for (int unsigned i = 0; i < FEAT_CNT; i++) begin
      if (w_wr && (r_feat_idx == FIDX_BITS'(i))) begin
        w_features[i*FEAT_BITS +: FEAT_BITS] = s_data;
      end
    end

    // s_ready and done follow the upcoming state so they stay registered
    w_s_ready = (w_state == LOAD);
    w_done    = (w_state == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LOAD;
      r_feat_idx   <= '0;
      r_sample_cnt <= '0;
      r_settle_cnt <= '0;
      r_features   <= '0;
      r_s_ready    <= 1'b1;
      r_m_valid    <= 1'b0;
      r_m_pred     <= '0;
      r_m_index    <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef TNN_LABEL_CHECK_EN
      r_label      <= '0;
      r_correct    <= '0;
`endif
    end else begin
      r_state      <= w_state;
      r_feat_idx   <= w_feat_idx;
      r_sample_cnt <= w_sample_cnt;
      r_settle_cnt <= w_settle_cnt;
      r_features   <= w_features;
      r_s_ready    <= w_s_ready;
      r_m_valid    <= w_m_valid;
      r_m_pred     <= w_m_pred;
      r_m_index    <= w_m_index;
      r_done       <= w_done;
      r_err        <= w_err;
`ifdef TNN_LABEL_CHECK_EN
      r_label      <= w_label;
      r_correct    <= w_correct;
`endif
    end
  end

  assign s_ready  = r_s_ready;
  assign features = r_features;
  assign m_valid  = r_m_valid;
  assign m_pred   = r_m_pred;
  assign m_index  = r_m_index;
  assign done     = r_done;
  assign err      = r_err;
`ifdef TNN_LABEL_CHECK_EN
  assign correct_cnt = r_correct;
`endif

endmodule

// File: tb/tb_tnn_feature_streamer.sv
// Bench for tnn_feature_streamer: DUT A at default parameters, DUT B with TEST_CNT=2 and
// SETTLE_CYCLES=3, both checked against a beat-level reference model.
`timescale 1ns/1ps
module tb_tnn_feature_streamer;

  localparam int unsigned FC   = 12;
  localparam int unsigned FB   = 4;
  localparam int unsigned PB   = 3;
  localparam int unsigned A_IB = 10;
  localparam int unsigned B_IB = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           a_s_valid, a_s_ready, a_s_last, a_m_valid, a_m_ready, a_done, a_err;
  logic [FB-1:0]  a_s_data;
  logic [FC*FB-1:0] a_features;
  logic [PB-1:0]  a_prediction, a_m_pred;
  logic [A_IB-1:0] a_m_index;

  logic           b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_done, b_err;
  logic [FB-1:0]  b_s_data;
  logic [FC*FB-1:0] b_features;
  logic [PB-1:0]  b_prediction, b_m_pred;
  logic [B_IB-1:0] b_m_index;

`ifdef TNN_LABEL_CHECK_EN
  logic [PB-1:0] a_s_label, b_s_label;
  logic [9:0]    a_correct;
  logic [1:0]    b_correct;
`endif

  tnn_feature_streamer #(.FEAT_CNT(12), .FEAT_BITS(4), .CLASS_CNT(6), .TEST_CNT(1000),
                         .SETTLE_CYCLES(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .s_last(a_s_last), .features(a_features), .prediction(a_prediction), .m_valid(a_m_valid),
    .m_ready(a_m_ready), .m_pred(a_m_pred), .m_index(a_m_index), .done(a_done), .err(a_err)
`ifdef TNN_LABEL_CHECK_EN
    , .s_label(a_s_label), .correct_cnt(a_correct)
`endif
  );

  tnn_feature_streamer #(.FEAT_CNT(12), .FEAT_BITS(4), .CLASS_CNT(6), .TEST_CNT(2),
                         .SETTLE_CYCLES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .s_last(b_s_last), .features(b_features), .prediction(b_prediction), .m_valid(b_m_valid),
    .m_ready(b_m_ready), .m_pred(b_m_pred), .m_index(b_m_index), .done(b_done), .err(b_err)
`ifdef TNN_LABEL_CHECK_EN
    , .s_label(b_s_label), .correct_cnt(b_correct)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model, one entry per DUT (0 = A, 1 = B)
  logic [3:0] m_feat [2][FC];
  int         m_pos [2];
  bit         m_err [2];
  int         m_idx [2];
  bit         m_done [2];
  logic [2:0] m_label [2];
  int         m_correct [2];

  function automatic int tc(input int sel);
    return (sel == 0) ? 1000 : 2;
  endfunction
  function automatic int settle(input int sel);
    return (sel == 0) ? 1 : 3;
  endfunction

  function automatic logic [47:0] model_feat(input int sel);
    logic [47:0] v = '0;
    for (int i = 0; i < FC; i++) v = v + (48'(m_feat[sel][i]) << (4 * i));
    return v;
  endfunction

  function automatic void model_reset(input int sel);
    for (int i = 0; i < FC; i++) m_feat[sel][i] = 4'h0;
    m_pos[sel] = 0; m_err[sel] = 0; m_idx[sel] = 0; m_done[sel] = 0;
    m_label[sel] = 3'd0; m_correct[sel] = 0;
  endfunction

  function automatic logic g_ready(input int sel);   return (sel == 0) ? a_s_ready : b_s_ready; endfunction
  function automatic logic g_valid(input int sel);   return (sel == 0) ? a_m_valid : b_m_valid; endfunction
  function automatic logic g_done(input int sel);    return (sel == 0) ? a_done : b_done; endfunction
  function automatic logic g_err(input int sel);     return (sel == 0) ? a_err : b_err; endfunction
  function automatic logic [2:0] g_pred(input int sel); return (sel == 0) ? a_m_pred : b_m_pred; endfunction
  function automatic logic [47:0] g_feat(input int sel); return (sel == 0) ? a_features : b_features; endfunction
  function automatic logic [9:0] g_idx(input int sel);
    return (sel == 0) ? a_m_index : 10'(b_m_index);
  endfunction
`ifdef TNN_LABEL_CHECK_EN
  function automatic logic [9:0] g_correct(input int sel);
    return (sel == 0) ? a_correct : 10'(b_correct);
  endfunction
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [3:0] d, input logic l,
                       input logic [2:0] lab);
    if (sel == 0) begin a_s_valid = v; a_s_data = d; a_s_last = l; end
    else          begin b_s_valid = v; b_s_data = d; b_s_last = l; end
`ifdef TNN_LABEL_CHECK_EN
    if (sel == 0) a_s_label = lab; else b_s_label = lab;
`endif
  endtask

  task automatic set_mready(input int sel, input logic v);
    if (sel == 0) a_m_ready = v; else b_m_ready = v;
  endtask

  task automatic set_pred(input int sel, input logic [2:0] p);
    if (sel == 0) a_prediction = p; else b_prediction = p;
  endtask

  task automatic check_reset(input int sel);
    check($sformatf("rst_flags%0d", sel), 64'({g_ready(sel), g_valid(sel), g_done(sel), g_err(sel)}), 64'(4'b1000));
    check($sformatf("rst_feat%0d", sel), 64'(g_feat(sel)), 64'd0);
    check($sformatf("rst_out%0d", sel), 64'({g_pred(sel), g_idx(sel)}), 64'd0);
`ifdef TNN_LABEL_CHECK_EN
    check($sformatf("rst_corr%0d", sel), 64'(g_correct(sel)), 64'd0);
`endif
  endtask

  // Offer one beat (after an optional idle gap), wait for acceptance, update the model
  task automatic send_beat(input int sel, input logic [3:0] d, input logic l,
                           input logic [2:0] lab, input int gap);
    int n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    drive(sel, 1'b1, d, l, lab);
    while (!g_ready(sel) && n < 40) begin @(posedge clk); #1; n++; end
    if (!g_ready(sel)) check("beat_timeout", 64'd0, 64'd1);
    if (l && m_pos[sel] < FC - 1) begin
      m_err[sel] = 1; m_pos[sel] = 0;
    end else begin
      m_feat[sel][m_pos[sel]] = d;
      if (m_pos[sel] == FC - 1) begin
        if (!l) m_err[sel] = 1;
        m_label[sel] = lab;
        m_pos[sel] = 0;
      end else begin
        m_pos[sel]++;
      end
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, 4'h0, 1'b0, 3'd0);
  endtask

  task automatic send_sample(input int sel, input logic [2:0] pred, input logic [2:0] lab,
                             input int abort_len, input bit drop_last, input int gap_max);
    set_pred(sel, pred);
    for (int i = 0; i < abort_len; i++)
      send_beat(sel, 4'($urandom_range(0, 15)), (i == abort_len - 1), 3'd0,
                $urandom_range(0, gap_max));
    for (int i = 0; i < FC; i++)
      send_beat(sel, 4'($urandom_range(0, 15)), (i == FC - 1) && !drop_last, lab,
                (i == FC - 1) ? 0 : $urandom_range(0, gap_max));
    check("features", 64'(g_feat(sel)), 64'(model_feat(sel)));
    check("err", 64'(g_err(sel)), 64'(m_err[sel]));
  endtask

  // Called right after the final beat; checks latency, payload, backpressure and handshake
  task automatic collect(input int sel, input logic [2:0] pred, input int stall);
    int n = 0;
    while (!g_valid(sel) && n < 30) begin @(posedge clk); #1; n++; end
    check("settle_latency", 64'(n), 64'(settle(sel)));
    check("m_pred", 64'(g_pred(sel)), 64'(pred));
    check("m_index", 64'(g_idx(sel)), 64'(m_idx[sel]));
    check("s_ready_in_out", 64'(g_ready(sel)), 64'd0);
    repeat (stall) begin
      @(posedge clk); #1;
      check("stall_hold", 64'({g_valid(sel), g_pred(sel), g_idx(sel), g_ready(sel)}),
            64'({1'b1, pred, 10'(m_idx[sel]), 1'b0}));
    end
    set_mready(sel, 1'b1);
    @(posedge clk); #1;
    set_mready(sel, 1'b0);
    if (pred == m_label[sel]) m_correct[sel]++;
    if (m_idx[sel] == tc(sel) - 1) m_done[sel] = 1; else m_idx[sel]++;
    check("m_valid_drop", 64'(g_valid(sel)), 64'd0);
    check("done", 64'(g_done(sel)), 64'(m_done[sel]));
    check("s_ready_after", 64'(g_ready(sel)), 64'(!m_done[sel]));
`ifdef TNN_LABEL_CHECK_EN
    check("correct_cnt", 64'(g_correct(sel)), 64'(m_correct[sel]));
`endif
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    drive(0, 1'b0, 4'h0, 1'b0, 3'd0); drive(1, 1'b0, 4'h0, 1'b0, 3'd0);
    set_mready(0, 1'b0); set_mready(1, 1'b0);
    #1;
    model_reset(0); model_reset(1);
    check_reset(0); check_reset(1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [47:0] hold;
    rst_n = 1'b0;
    drive(0, 1'b0, 4'h0, 1'b0, 3'd0); drive(1, 1'b0, 4'h0, 1'b0, 3'd0);
    set_mready(0, 1'b0); set_mready(1, 1'b0);
    set_pred(0, 3'd0); set_pred(1, 3'd0);
    model_reset(0); model_reset(1);
    repeat (3) @(posedge clk);
    #1;
    check_reset(0); check_reset(1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic load 1..12 with prediction 3, then 5 cycles of backpressure
    set_pred(0, 3'd3);
    for (int i = 1; i <= FC; i++) send_beat(0, 4'(i), (i == FC), 3'd3, 0);
    check("basic_features", 64'(a_features), 64'(48'hCBA987654321));
    check("basic_err", 64'(a_err), 64'd0);
    collect(0, 3'd3, 5);
    send_sample(0, 3'd5, 3'd0, 0, 1'b0, 0);
    collect(0, 3'd5, 0);

    // Early s_last on the 5th beat after a fresh reset
    pulse_reset();
    for (int i = 1; i <= 5; i++) send_beat(0, 4'(i + 8), (i == 5), 3'd0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_flags", 64'({a_err, a_m_valid, a_s_ready}), 64'(3'b101));
    check("abort_feat", 64'(a_features), 64'(model_feat(0)));
    send_sample(0, 3'd2, 3'd2, 0, 1'b0, 1);
    collect(0, 3'd2, 1);

    // Run end on DUT B: two samples, then done and beats ignored
    send_sample(1, 3'd4, 3'd4, 0, 1'b0, 0);
    collect(1, 3'd4, 2);
    send_sample(1, 3'd1, 3'd0, 0, 1'b0, 1);
    collect(1, 3'd1, 0);
    hold = model_feat(1);
    drive(1, 1'b1, 4'hF, 1'b1, 3'd0);
    repeat (5) begin
      @(posedge clk); #1;
      check("done_ignore", 64'({b_s_ready, b_m_valid, b_done}), 64'(3'b001));
      check("done_feat", 64'(b_features), 64'(hold));
    end
    drive(1, 1'b0, 4'h0, 1'b0, 3'd0);

    // Reset mid-LOAD at beat 7, then mid-OUT
    for (int i = 0; i < 7; i++) send_beat(0, 4'($urandom_range(1, 15)), 1'b0, 3'd0, 0);
    pulse_reset();
    send_sample(0, 3'd1, 3'd1, 0, 1'b0, 0);
    n = 0;
    while (!a_m_valid && n < 10) begin @(posedge clk); #1; n++; end
    check("pre_reset_valid", 64'(a_m_valid), 64'd1);
    pulse_reset();
    send_sample(0, 3'd3, 3'd3, 0, 1'b0, 0);
    collect(0, 3'd3, 0);

    // Randomized samples with aborts, missing s_last, gaps and stalls
    for (int k = 0; k < 25; k++) begin
      logic [2:0] p;
      p = 3'($urandom_range(0, 5));
      send_sample(0, p, 3'($urandom_range(0, 5)),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 11) : 0,
                  ($urandom_range(0, 7) == 0), 2);
      collect(0, p, $urandom_range(0, 3));
    end

`ifdef TNN_LABEL_CHECK_EN
    // Labels 3,2,3 against prediction 3: correct_cnt 1,1,2
    pulse_reset();
    send_sample(0, 3'd3, 3'd3, 0, 1'b0, 0); collect(0, 3'd3, 0);
    check("label_cnt1", 64'(a_correct), 64'd1);
    send_sample(0, 3'd3, 3'd2, 0, 1'b0, 0); collect(0, 3'd3, 0);
    check("label_cnt2", 64'(a_correct), 64'd1);
    send_sample(0, 3'd3, 3'd3, 0, 1'b0, 0); collect(0, 3'd3, 0);
    check("label_cnt3", 64'(a_correct), 64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tnn_feature_streamer.md
# tnn_feature_streamer

Sequential front end for the combinational ternary-NN classifiers (TNN parallel-weight products). It accepts feature values one per beat on a valid/ready stream and packs them into the flat `features` vector the classifier consumes. It holds that vector stable while the classifier settles, then captures the classifier's `prediction` and returns it on an output valid/ready stream with a sample index. It sequences a full test run of TEST_CNT samples and then stops.

## Interface
- FEAT_CNT, 12, features per sample
- FEAT_BITS, 4, bits per feature (unsigned)
- CLASS_CNT, 6, classifier class count; PRED_BITS = $clog2(CLASS_CNT)
- TEST_CNT, 1000, samples per run; IDX_BITS = $clog2(TEST_CNT)
- SETTLE_CYCLES, 1, cycles `features` is held before `prediction` is sampled (≥1)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  input feature beat valid
- s_ready  out  1  streamer can accept a beat
- s_data  in  FEAT_BITS  feature value
- s_last  in  1  marks the final feature of a sample
- features  out  FEAT_CNT*FEAT_BITS  to classifier; feature i at [i*FEAT_BITS +: FEAT_BITS]
- prediction  in  PRED_BITS  from classifier
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- m_pred  out  PRED_BITS  captured prediction
- m_index  out  IDX_BITS  sample number of m_pred, from 0
- done  out  1  run complete
- err  out  1  sticky framing error

## Operation
- FSM states: LOAD, SETTLE, OUT, DONE. Reset state is LOAD.
- LOAD:
  - s_ready=1. Each accepted beat (s_valid&s_ready) writes s_data into slot feat_idx, then feat_idx++.
  - Beat with feat_idx==FEAT_CNT-1 → SETTLE with settle_cnt=SETTLE_CYCLES, feat_idx=0.
- Framing:
  - s_last on a beat with feat_idx<FEAT_CNT-1: sample aborted. Beat is not written, err set, feat_idx=0, stay LOAD. The partial slots keep stale data.
  - Final beat without s_last: err set, sample proceeds normally.
- SETTLE:
  - s_ready=0, `features` unchanged, settle_cnt decrements each cycle.
  - In the cycle with settle_cnt==1: capture m_pred<=prediction, m_index<=sample_cnt, m_valid<=1, → OUT.
- OUT:
  - m_valid=1, m_pred/m_index stable until m_ready.
  - On handshake: m_valid<=0. If sample_cnt==TEST_CNT-1 → DONE, else sample_cnt++ and → LOAD.
- DONE: done=1, s_ready=0, m_valid=0. Held until reset. Beats offered here are ignored.
- `features` changes only on accepted LOAD beats and is never cleared except by reset.
- Reset (any state, asynchronous): state=LOAD, features=0, feat_idx=0, sample_cnt=0, settle_cnt=0, m_valid=0, m_pred=0, m_index=0, done=0, err=0. Reset during SETTLE/OUT drops the pending result.

## Timing
- s_ready is a registered function of state only, with no combinational path from m_ready or s_valid.
- Last beat accepted on edge t: SETTLE occupies t..t+SETTLE_CYCLES-1. m_valid is high after edge t+SETTLE_CYCLES (defaults: one cycle after the last beat).
- OUT→LOAD: s_ready high the cycle after the m_ready handshake.
- Minimum period per sample: FEAT_CNT + SETTLE_CYCLES + 1 cycles (14 at defaults).
- m_valid never drops without a handshake, except on reset.

## Configuration
- `TNN_LABEL_CHECK_EN` defined:
  - Adds input s_label [PRED_BITS-1:0], captured on the final beat of a sample.
  - Adds output correct_cnt [$clog2(TEST_CNT+1)-1:0], reset 0. It increments on each OUT handshake where m_pred==captured label.
  - An aborted sample does not update the label.
- Undefined: neither port exists. All other behaviour is identical.

## Test plan
- Basic load, defaults: send s_data=1..12, s_last on the 12th beat, with prediction tied to 3 → features=48'hCBA987654321, m_valid rises 1 cycle after the last beat, m_pred=3, m_index=0, err=0.
- Backpressure: hold m_ready=0 for 5 cycles in OUT → m_valid, m_pred and m_index stay stable, s_ready=0 throughout. With m_ready=1, s_ready rises the next cycle and m_index=1 on the following sample.
- Early s_last on the 5th beat → err=1, no m_valid. A following clean 12-beat sample produces a result with m_index=0. err stays 1.
- Run end, TEST_CNT=2, SETTLE_CYCLES=3 → m_valid rises 3 cycles after each last beat. After the 2nd handshake done=1, s_ready=0, and further beats are ignored.
- Async reset: assert rst_n=0 mid-LOAD at beat 7 and mid-OUT → all outputs return to their reset values immediately. After release, a new sample gives m_index=0.
- `TNN_LABEL_CHECK_EN`, prediction=3: labels 3,2,3 over three samples → correct_cnt reads 1, 1, 2 after each handshake.
